video_timing: RTL and testbench
===============================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter p_H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter p_H_FRONT, default 16, horizontal front porch pixels.
REQ-003 SHALL have parameter p_H_SYNC, default 96, horizontal sync pixels.
REQ-004 SHALL have parameter p_H_BACK, default 48, horizontal back porch pixels.
REQ-005 SHALL have parameter p_V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter p_V_FRONT, default 10, vertical front porch lines.
REQ-007 SHALL have parameter p_V_SYNC, default 2, vertical sync lines.
REQ-008 SHALL have parameter p_V_BACK, default 33, vertical back porch lines.
REQ-009 SHALL have port i_Clk, input, 1, pixel clock (25 MHz); sole clock domain.
REQ-010 SHALL have port i_Reset, input, 1, synchronous active-high reset.
REQ-011 SHALL have port o_HSync, output, 1, horizontal sync, active-low.
REQ-012 SHALL have port o_VSync, output, 1, vertical sync, active-low; drives the paddle 555 trigger.
REQ-013 SHALL have port o_HReset, output, 1, one-pixel pulse on the last pixel of every line.
REQ-014 SHALL have port o_VReset, output, 1, one-pixel pulse on the last pixel of every frame.
REQ-015 SHALL have port o_Active, output, 1, high inside the visible area.
REQ-016 SHALL have ports o_Col and o_Row, output, 10 each, current pixel column and line.

Function
REQ-017 SHALL define H_TOTAL = sum of the four H parameters (800) and V_TOTAL = sum of the four V parameters (525); both ≤ 1024.
REQ-018 SHALL keep a 10-bit column counter h advancing 0..H_TOTAL-1 by one per advance cycle, wrapping to 0.
REQ-019 SHALL keep a 10-bit row counter v advancing by one only when h wraps, wrapping 0..V_TOTAL-1 to 0.
REQ-020 SHALL drive o_Col = h and o_Row = v, and decode all outputs combinationally from h/v with zero latency.
REQ-021 SHALL drive o_HSync low for h in [p_H_ACTIVE+p_H_FRONT, p_H_ACTIVE+p_H_FRONT+p_H_SYNC-1] (656..751), high otherwise.
REQ-022 SHALL drive o_VSync low for v in [p_V_ACTIVE+p_V_FRONT, p_V_ACTIVE+p_V_FRONT+p_V_SYNC-1] (490..491), high otherwise, for all h of those lines.
REQ-023 SHALL drive o_Active high iff h < p_H_ACTIVE and v < p_V_ACTIVE.
REQ-024 SHALL drive o_HReset high iff h = H_TOTAL-1 on an advance cycle.
REQ-025 SHALL drive o_VReset high iff h = H_TOTAL-1 and v = V_TOTAL-1 on an advance cycle; o_VReset implies o_HReset in the same cycle.
REQ-026 SHALL treat every cycle as an advance cycle unless REQ-032 applies.

Reset
REQ-027 SHALL, on i_Reset high at a rising i_Clk edge, load h = 0 and v = 0 regardless of any other input.
REQ-028 SHALL therefore present after reset: o_Col=0, o_Row=0, o_HSync=1, o_VSync=1, o_Active=1, o_HReset=0, o_VReset=0.
REQ-029 SHALL, on reset asserted mid-line or mid-frame, abandon the current frame with no o_HReset/o_VReset pulse and restart at pixel (0,0) on the first cycle after reset deasserts.
REQ-030 SHALL hold h = v = 0 for as long as i_Reset stays high.

Configuration
REQ-031 SHALL honour the macro VIDEO_TIMING_CLK_EN_EN.
REQ-032 With VIDEO_TIMING_CLK_EN_EN defined, SHALL add input i_ClkEn (1 bit); h/v advance only on cycles with i_ClkEn high, hold otherwise, and o_HReset/o_VReset are gated by i_ClkEn so each pulse lasts exactly one cycle; reset overrides i_ClkEn.
REQ-033 Without VIDEO_TIMING_CLK_EN_EN, SHALL have no i_ClkEn port and advance every cycle.

Verification
REQ-034 SHALL cover: release reset, run 800 cycles -> o_HReset high only at cycle 799 (h=799), o_Row steps 0->1 on cycle 800.
REQ-035 SHALL cover: free-run one frame (420000 cycles) -> o_VReset exactly once, at h=799/v=524, coincident with o_HReset; counters then read (0,0).
REQ-036 SHALL cover: line 0 -> o_HSync low for exactly 96 cycles starting at h=656; o_VSync low exactly for v=490..491 (1600 cycles).
REQ-037 SHALL cover: o_Active count per frame = 307200 cycles; low at h=640 and at v=480.
REQ-038 SHALL cover: assert i_Reset for 3 cycles at h=500/v=300 -> next cycle after release o_Col=0, o_Row=0, o_HSync=1, no o_HReset pulse emitted.
REQ-039 SHALL cover, with VIDEO_TIMING_CLK_EN_EN: i_ClkEn toggling 1/0 -> line takes 1600 cycles, o_HReset high for exactly one cycle per line.

Source files
------------

// File: rtl/video_timing.sv
// Raster timing generator: free-running column/row counters with zero-latency sync, blanking and wrap decodes.
// Optional pixel clock enable selected by macro VIDEO_TIMING_CLK_EN_EN (adds input i_ClkEn).
module video_timing #(
  parameter int unsigned p_H_ACTIVE = 640,
  parameter int unsigned p_H_FRONT  = 16,
  parameter int unsigned p_H_SYNC   = 96,
  parameter int unsigned p_H_BACK   = 48,
  parameter int unsigned p_V_ACTIVE = 480,
  parameter int unsigned p_V_FRONT  = 10,
  parameter int unsigned p_V_SYNC   = 2,
  parameter int unsigned p_V_BACK   = 33
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
`ifdef VIDEO_TIMING_CLK_EN_EN
  input  logic       i_ClkEn,
`endif
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_HReset,
  output logic       o_VReset,
  output logic       o_Active,
  output logic [9:0] o_Col,
  output logic [9:0] o_Row
);

  localparam int unsigned H_TOTAL = p_H_ACTIVE + p_H_FRONT + p_H_SYNC + p_H_BACK;
  localparam int unsigned V_TOTAL = p_V_ACTIVE + p_V_FRONT + p_V_SYNC + p_V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(p_H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(p_V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(p_H_ACTIVE + p_H_FRONT);
  localparam logic [9:0] HS_END   = 10'(p_H_ACTIVE + p_H_FRONT + p_H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(p_V_ACTIVE + p_V_FRONT);
  localparam logic [9:0] VS_END   = 10'(p_V_ACTIVE + p_V_FRONT + p_V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       adv;
  logic       h_last;
  logic       v_last;

  // A reset cycle is never an advance cycle, so an abandoned line emits no wrap pulse.
`ifdef VIDEO_TIMING_CLK_EN_EN
  assign adv = i_ClkEn & ~i_Reset;
`else
  assign adv = ~i_Reset;
`endif

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_last) begin
        h_d = 10'd0;
        v_d = v_last ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign o_Col    = h_q;
  assign o_Row    = v_q;
  assign o_HSync  = ~((h_q >= HS_START) && (h_q <= HS_END));
  assign o_VSync  = ~((v_q >= VS_START) && (v_q <= VS_END));
  assign o_Active = (h_q < H_ACT) && (v_q < V_ACT);
  assign o_HReset = adv & h_last;
  assign o_VReset = adv & h_last & v_last;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench: full-width 800-pixel lines with a shortened 29-line frame (20/4/2/3) to keep whole-frame runs short.
// Clock-enable scenario is built only when VIDEO_TIMING_CLK_EN_EN is defined.
module tb_video_timing;

  localparam int HT = 800;
  localparam int VA = 20;
  localparam int VT = 29;
  localparam int VS0 = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs, vs, hr, vr, act;
  logic [9:0] col, row;
`ifdef VIDEO_TIMING_CLK_EN_EN
  logic       clk_en = 1'b1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  video_timing #(
    .p_H_ACTIVE(640), .p_H_FRONT(16), .p_H_SYNC(96), .p_H_BACK(48),
    .p_V_ACTIVE(VA),  .p_V_FRONT(4),  .p_V_SYNC(2),  .p_V_BACK(3)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
`ifdef VIDEO_TIMING_CLK_EN_EN
    .i_ClkEn (clk_en),
`endif
    .o_HSync (hs),
    .o_VSync (vs),
    .o_HReset(hr),
    .o_VReset(vr),
    .o_Active(act),
    .o_Col   (col),
    .o_Row   (row)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (col !== 10'd0) begin fails++; $display("FAIL reset_col got %0d want 0", col); end
    tests++; if (row !== 10'd0) begin fails++; $display("FAIL reset_row got %0d want 0", row); end
    tests++; if (hs !== 1'b1) begin fails++; $display("FAIL reset_hsync got %b want 1", hs); end
    tests++; if (vs !== 1'b1) begin fails++; $display("FAIL reset_vsync got %b want 1", vs); end
    tests++; if (act !== 1'b1) begin fails++; $display("FAIL reset_active got %b want 1", act); end
    tests++; if (hr !== 1'b0) begin fails++; $display("FAIL reset_hreset got %b want 0", hr); end
    tests++; if (vr !== 1'b0) begin fails++; $display("FAIL reset_vreset got %b want 0", vr); end
    rst = 1'b0;
  endtask

  task automatic test_line();
    int hr_cnt = 0, hr_at = -1, hs_cnt = 0, hs_first = -1, col_bad = 0, act_bad = 0;
    do_reset();
    for (int k = 0; k < HT; k++) begin
      if (hr === 1'b1) begin hr_cnt++; hr_at = k; end
      if (hs === 1'b0) begin hs_cnt++; if (hs_first < 0) hs_first = k; end
      if (col !== 10'(k) || row !== 10'd0) col_bad++;
      if (act !== (k < 640)) act_bad++;
      step();
    end
    tests++; if (hr_cnt !== 1 || hr_at !== 799) begin fails++; $display("FAIL line_hreset count %0d at %0d want 1 at 799", hr_cnt, hr_at); end
    tests++; if (hs_cnt !== 96 || hs_first !== 656) begin fails++; $display("FAIL line_hsync low %0d from %0d want 96 from 656", hs_cnt, hs_first); end
    tests++; if (col_bad !== 0) begin fails++; $display("FAIL line_col bad cycles %0d want 0", col_bad); end
    tests++; if (act_bad !== 0) begin fails++; $display("FAIL line_active bad cycles %0d want 0", act_bad); end
    tests++; if (row !== 10'd1 || col !== 10'd0) begin fails++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", col, row); end
  endtask

  task automatic test_frame();
    int vr_cnt = 0, vr_h = -1, vr_v = -1, vr_no_hr = 0;
    int act_cnt = 0, vs_cnt = 0, vs_bad = 0, pos_bad = 0, act_v_edge = -1;
    int hx = 0, vx = 0;
    do_reset();
    for (int k = 0; k < HT * VT; k++) begin
      if (vr === 1'b1) begin
        vr_cnt++; vr_h = int'(col); vr_v = int'(row);
        if (hr !== 1'b1) vr_no_hr++;
      end
      if (act === 1'b1) act_cnt++;
      if (vs === 1'b0) vs_cnt++;
      if (vs !== !(vx == VS0 || vx == VS0 + 1)) vs_bad++;
      if (col !== 10'(hx) || row !== 10'(vx)) pos_bad++;
      if (hx == 0 && vx == VA) act_v_edge = int'(act);
      step();
      if (hx == HT - 1) begin hx = 0; vx = (vx == VT - 1) ? 0 : vx + 1; end
      else hx++;
    end
    tests++; if (vr_cnt !== 1 || vr_h !== 799 || vr_v !== VT - 1) begin fails++; $display("FAIL frame_vreset count %0d at (%0d,%0d) want 1 at (799,%0d)", vr_cnt, vr_h, vr_v, VT - 1); end
    tests++; if (vr_no_hr !== 0) begin fails++; $display("FAIL frame_vreset_without_hreset got %0d want 0", vr_no_hr); end
    tests++; if (act_cnt !== 640 * VA) begin fails++; $display("FAIL frame_active_count got %0d want %0d", act_cnt, 640 * VA); end
    tests++; if (act_v_edge !== 0) begin fails++; $display("FAIL frame_active_at_vactive got %0d want 0", act_v_edge); end
    tests++; if (vs_cnt !== 1600 || vs_bad !== 0) begin fails++; $display("FAIL frame_vsync low %0d misplaced %0d want 1600 and 0", vs_cnt, vs_bad); end
    tests++; if (pos_bad !== 0) begin fails++; $display("FAIL frame_position bad cycles %0d want 0", pos_bad); end
    tests++; if (col !== 10'd0 || row !== 10'd0) begin fails++; $display("FAIL frame_wrap got (%0d,%0d) want (0,0)", col, row); end
  endtask

  task automatic test_reset_mid();
    int hr_cnt = 0;
    do_reset();
    for (int k = 0; k < 15 * HT + 500; k++) step();
    tests++; if (col !== 10'd500 || row !== 10'd15) begin fails++; $display("FAIL mid_position got (%0d,%0d) want (500,15)", col, row); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (hr === 1'b1) hr_cnt++;
    end
    rst = 1'b0;
    tests++; if (col !== 10'd0 || row !== 10'd0) begin fails++; $display("FAIL mid_restart got (%0d,%0d) want (0,0)", col, row); end
    tests++; if (hs !== 1'b1 || hr !== 1'b0 || hr_cnt !== 0) begin fails++; $display("FAIL mid_outputs hsync %b hreset %b pulses %0d want 1 0 0", hs, hr, hr_cnt); end
    step();
    tests++; if (col !== 10'd1) begin fails++; $display("FAIL mid_advance got %0d want 1", col); end
  endtask

  task automatic test_reset_at_wrap();
    do_reset();
    for (int k = 0; k < HT - 1; k++) step();
    tests++; if (col !== 10'd799 || hr !== 1'b1) begin fails++; $display("FAIL wrap_pre col %0d hreset %b want 799 1", col, hr); end
    rst = 1'b1;
    #1;
    tests++; if (hr !== 1'b0 || vr !== 1'b0) begin fails++; $display("FAIL wrap_reset_pulse hreset %b vreset %b want 0 0", hr, vr); end
    step();
    rst = 1'b0;
    tests++; if (col !== 10'd0 || row !== 10'd0) begin fails++; $display("FAIL wrap_reset_pos got (%0d,%0d) want (0,0)", col, row); end
  endtask

`ifdef VIDEO_TIMING_CLK_EN_EN
  task automatic test_clken();
    int hr_cnt = 0, hr_at = -1;
    clk_en = 1'b1;
    do_reset();
    for (int c = 0; c < 2 * HT; c++) begin
      clk_en = (c % 2 == 0);
      #1;
      if (hr === 1'b1) begin hr_cnt++; hr_at = c; end
      step();
    end
    clk_en = 1'b1;
    tests++; if (hr_cnt !== 1 || hr_at !== 1598) begin fails++; $display("FAIL clken_hreset count %0d at %0d want 1 at 1598", hr_cnt, hr_at); end
    tests++; if (row !== 10'd1 || col !== 10'd0) begin fails++; $display("FAIL clken_wrap got (%0d,%0d) want (0,1)", col, row); end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_reset_mid();
    test_reset_at_wrap();
`ifdef VIDEO_TIMING_CLK_EN_EN
    test_clken();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
